// File: rtl/rw_manager_m10_pkg.sv
// rtl/rw_manager_m10_pkg.sv - shared field positions, state encoding and parameter defaults
package rw_manager_m10_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int INST_W_DEF = 20;
    localparam int CNT_W_DEF  = 8;

    localparam int END_BIT    = 19;
    localparam int JSEL_HI    = 18;
    localparam int JSEL_LO    = 17;
    localparam int PAYLOAD_HI = 16;
    localparam int PAYLOAD_W  = 17;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ADDR  = 2'd1,
        ST_DATA  = 2'd2,
        ST_ISSUE = 2'd3
    } state_t;

endpackage

// File: rtl/rw_manager_m10_inst_seq_if.sv
// rtl/rw_manager_m10_inst_seq_if.sv - command handshake bundle between sequencer and datapath
interface rw_manager_m10_inst_seq_if
    import rw_manager_m10_pkg::*;
;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [PAYLOAD_W-1:0] cmd_payload;

    modport master (output cmd_valid, output cmd_payload, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_payload, output cmd_ready);
endinterface

// File: rtl/rw_manager_m10_loop_cnt.sv
// rtl/rw_manager_m10_loop_cnt.sv - three loop counter / jump target pairs with load, decrement and zero flags
module rw_manager_m10_loop_cnt #(
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ld_en,
    input  logic [1:0]        i_ld_sel,
    input  logic [CNT_W-1:0]  i_ld_cnt_val,
    input  logic [ADDR_W-1:0] i_ld_jump_addr,
    input  logic              i_dec_en,
    input  logic [1:0]        i_sel,
    output logic              o_sel_zero,
    output logic [ADDR_W-1:0] o_sel_jump
);

    logic [CNT_W-1:0]  r_cnt  [1:3];
    logic [ADDR_W-1:0] r_jump [1:3];
    logic [3:1]        w_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 1; i <= 3; i++) begin
                r_cnt[i]  <= '0;
                r_jump[i] <= '0;
            end
        end else begin
            for (int i = 1; i <= 3; i++) begin
                if (i_ld_en && i_ld_sel == 2'(i)) begin
                    r_cnt[i]  <= i_ld_cnt_val;
                    r_jump[i] <= i_ld_jump_addr;
                end else if (i_dec_en && i_sel == 2'(i)) begin
                    r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        for (int i = 1; i <= 3; i++) begin
            w_zero[i] = (r_cnt[i] == '0);
        end
    end

    // Select 0 never jumps, so report it as exhausted.
    always_comb begin
        o_sel_zero = 1'b1;
        o_sel_jump = '0;
        for (int i = 1; i <= 3; i++) begin
            if (i_sel == 2'(i)) begin
                o_sel_zero = w_zero[i];
                o_sel_jump = r_jump[i];
            end
        end
    end

endmodule

// File: rtl/rw_manager_m10_inst_seq.sv
// rtl/rw_manager_m10_inst_seq.sv - fetches instructions from an external ROM and issues them as commands
module rw_manager_m10_inst_seq
    import rw_manager_m10_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                        avl_clk,
    input  logic                        avl_reset_n,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           start_addr,
    input  logic                        ld_cnt,
    input  logic [1:0]                  ld_sel,
    input  logic [CNT_W-1:0]            ld_cnt_val,
    input  logic [ADDR_W-1:0]           ld_jump_addr,
    output logic [ADDR_W-1:0]           rom_rdaddress,
    input  logic [INST_W-1:0]           rom_q,
    rw_manager_m10_inst_seq_if.master   cmd_if,
    output logic                        busy,
    output logic                        done
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_ir;
    logic              r_done;

    logic              w_hs;
    logic              w_end;
    logic [1:0]        w_jsel;
    logic              w_sel_zero;
    logic [ADDR_W-1:0] w_sel_jump;
    logic              w_take_jump;
    logic              w_ld_en;

    assign w_hs        = (r_state == ST_ISSUE) && cmd_if.cmd_ready;
    assign w_end       = r_ir[END_BIT];
    assign w_jsel      = r_ir[JSEL_HI:JSEL_LO];
    assign w_take_jump = w_hs && !w_end && (w_jsel != 2'd0) && !w_sel_zero;
    assign w_ld_en     = (r_state == ST_IDLE) && ld_cnt && (ld_sel != 2'd0);

    rw_manager_m10_loop_cnt #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_loop_cnt (
        .i_clk          (avl_clk),
        .i_rst_n        (avl_reset_n),
        .i_ld_en        (w_ld_en),
        .i_ld_sel       (ld_sel),
        .i_ld_cnt_val   (ld_cnt_val),
        .i_ld_jump_addr (ld_jump_addr),
        .i_dec_en       (w_take_jump),
        .i_sel          (w_jsel),
        .o_sel_zero     (w_sel_zero),
        .o_sel_jump     (w_sel_jump)
    );

    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_ADDR;
            ST_ADDR:  w_next = ST_DATA;
            ST_DATA:  w_next = ST_ISSUE;
            ST_ISSUE: if (w_hs) w_next = w_end ? ST_IDLE : ST_ADDR;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_if.cmd_valid   = (r_state == ST_ISSUE);
        cmd_if.cmd_payload = r_ir[PAYLOAD_HI:0];
        busy               = (r_state != ST_IDLE);
        done               = r_done;
        rom_rdaddress      = r_pc;
    end

    // pc holds its value on END so the final address stays visible after done.
    always_ff @(posedge avl_clk or negedge avl_reset_n) begin
        if (!avl_reset_n) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs && w_end;
            if (r_state == ST_IDLE && start) begin
                r_pc <= start_addr;
            end else if (w_hs && !w_end) begin
                r_pc <= w_take_jump ? w_sel_jump : r_pc + ADDR_W'(1);
            end
            if (r_state == ST_DATA) begin
                r_ir <= rom_q;
            end
        end
    end

endmodule

// File: tb/tb_rw_manager_m10_inst_seq.sv
// tb/tb_rw_manager_m10_inst_seq.sv - self-checking bench for rw_manager_m10_inst_seq
module tb_rw_manager_m10_inst_seq;

    logic        avl_clk;
    logic        avl_reset_n;
    logic        start;
    logic [6:0]  start_addr;
    logic        ld_cnt;
    logic [1:0]  ld_sel;
    logic [7:0]  ld_cnt_val;
    logic [6:0]  ld_jump_addr;
    logic [6:0]  rom_rdaddress;
    logic [19:0] rom_q;
    logic        busy;
    logic        done;

    rw_manager_m10_inst_seq_if cmd_if ();

    rw_manager_m10_inst_seq dut (
        .avl_clk       (avl_clk),
        .avl_reset_n   (avl_reset_n),
        .start         (start),
        .start_addr    (start_addr),
        .ld_cnt        (ld_cnt),
        .ld_sel        (ld_sel),
        .ld_cnt_val    (ld_cnt_val),
        .ld_jump_addr  (ld_jump_addr),
        .rom_rdaddress (rom_rdaddress),
        .rom_q         (rom_q),
        .cmd_if        (cmd_if.master),
        .busy          (busy),
        .done          (done)
    );

    logic [19:0] rom_mem [128];
    logic [16:0] exp_q [$];
    logic [16:0] got_q [$];
    logic [6:0]  exp_end_pc;
    int          m_cnt  [4];
    logic [6:0]  m_jump [4];
    int          checks;
    int          failures;

    initial begin
        avl_clk = 1'b0;
        forever #5 avl_clk = ~avl_clk;
    end

    always @(posedge avl_clk) rom_q <= rom_mem[rom_rdaddress];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walks the program the way the instruction set defines it, ignoring cycle timing.
    task automatic model_run(input logic [6:0] sa);
        logic [6:0]  pc;
        logic [19:0] inst;
        int          j;
        pc = sa;
        exp_q.delete();
        for (int n = 0; n < 1000; n++) begin
            inst = rom_mem[pc];
            exp_q.push_back(inst[16:0]);
            if (inst[19]) break;
            j = int'(inst[18:17]);
            if (j != 0 && m_cnt[j] != 0) begin
                m_cnt[j] = m_cnt[j] - 1;
                pc = m_jump[j];
            end else begin
                pc = pc + 7'd1;
            end
        end
        exp_end_pc = pc;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_cnt[k]  = 0;
            m_jump[k] = 7'd0;
        end
    endtask

    task automatic do_load(input logic [1:0] sel, input logic [7:0] val, input logic [6:0] jaddr);
        @(posedge avl_clk); #1;
        ld_cnt = 1'b1; ld_sel = sel; ld_cnt_val = val; ld_jump_addr = jaddr;
        @(posedge avl_clk); #1;
        ld_cnt = 1'b0;
        if (sel != 2'd0) begin
            m_cnt[sel]  = int'(val);
            m_jump[sel] = jaddr;
        end
    endtask

    task automatic run_seq(input logic [6:0] sa, input bit rnd, input bit inject, input bit co_load,
                           input logic [1:0] cl_sel, input logic [7:0] cl_val, input logic [6:0] cl_jmp);
        int          lat, d_cyc, h_cyc, prev_h;
        bit          stall, done_seen;
        logic [16:0] hold_p;
        logic [6:0]  hold_a;
        if (co_load && cl_sel != 2'd0) begin
            m_cnt[cl_sel]  = int'(cl_val);
            m_jump[cl_sel] = cl_jmp;
        end
        model_run(sa);
        got_q.delete();
        lat = -1; d_cyc = -1; h_cyc = -1; prev_h = -1; stall = 0; done_seen = 0;
        hold_p = '0; hold_a = '0;
        @(posedge avl_clk); #1;
        start = 1'b1; start_addr = sa;
        cmd_if.cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (co_load) begin
            ld_cnt = 1'b1; ld_sel = cl_sel; ld_cnt_val = cl_val; ld_jump_addr = cl_jmp;
        end
        @(posedge avl_clk); #1;
        start = 1'b0; ld_cnt = 1'b0;
        for (int c = 0; c < 3000 && !done_seen; c++) begin
            @(negedge avl_clk);
            if (stall) begin
                check("stall_valid", 32'(cmd_if.cmd_valid), 32'd1);
                check("stall_payload", 32'(cmd_if.cmd_payload), 32'(hold_p));
                check("stall_pc", 32'(rom_rdaddress), 32'(hold_a));
            end
            if (lat < 0 && cmd_if.cmd_valid) lat = c + 1;
            if (done) begin
                done_seen = 1;
                d_cyc = c;
            end
            stall  = cmd_if.cmd_valid && !cmd_if.cmd_ready;
            hold_p = cmd_if.cmd_payload;
            hold_a = rom_rdaddress;
            if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
                if (!rnd && prev_h >= 0) check("issue_spacing", 32'(c - prev_h), 32'd3);
                got_q.push_back(cmd_if.cmd_payload);
                prev_h = c;
                h_cyc  = c;
            end
            if (!done_seen) begin
                @(posedge avl_clk); #1;
                cmd_if.cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                start  = 1'b0;
                ld_cnt = 1'b0;
                if (inject && c == 0) begin
                    start = 1'b1; start_addr = sa + 7'd37;
                    ld_cnt = 1'b1; ld_sel = 2'd1; ld_cnt_val = 8'd9; ld_jump_addr = sa + 7'd50;
                end
            end
        end
        check("done_seen", 32'(done_seen), 32'd1);
        check("first_valid_latency", 32'(lat), 32'd3);
        check("done_after_handshake", 32'(d_cyc), 32'(h_cyc + 1));
        check("busy_at_done", 32'(busy), 32'd0);
        check("cmd_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("payload[%0d]", i), 32'(got_q[i]), 32'(exp_q[i]));
        check("end_pc", 32'(rom_rdaddress), 32'(exp_end_pc));
        @(negedge avl_clk);
        check("done_pulse_width", 32'(done), 32'd0);
        check("idle_valid", 32'(cmd_if.cmd_valid), 32'd0);
    endtask

    initial begin
        logic [16:0] exp042 [7];
        logic [6:0]  b;
        int          len;
        bit          got_valid;
        checks = 0; failures = 0;
        for (int a = 0; a < 128; a++) rom_mem[a] = 20'h0;
        model_reset();
        avl_reset_n = 1'b0; start = 1'b0; start_addr = '0; ld_cnt = 1'b0; ld_sel = '0;
        ld_cnt_val = '0; ld_jump_addr = '0; cmd_if.cmd_ready = 1'b0;
        repeat (3) @(posedge avl_clk);
        @(negedge avl_clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_valid", 32'(cmd_if.cmd_valid), 32'd0);
        check("reset_payload", 32'(cmd_if.cmd_payload), 32'd0);
        check("reset_pc", 32'(rom_rdaddress), 32'd0);
        avl_reset_n = 1'b1;

        // Single END instruction.
        rom_mem[7'h00] = 20'h80180;
        run_seq(7'h00, 0, 0, 0, 2'd0, 8'd0, 7'd0);
        check("single_len", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) check("single_payload", 32'(got_q[0]), 32'h00180);

        // Counted loop: count 2 gives three passes through the body.
        rom_mem[7'h10] = 20'h00000;
        rom_mem[7'h11] = 20'h20AE0;
        rom_mem[7'h12] = 20'h80000;
        do_load(2'd1, 8'd2, 7'h10);
        run_seq(7'h10, 0, 0, 0, 2'd0, 8'd0, 7'd0);
        exp042 = '{17'h0, 17'h0AE0, 17'h0, 17'h0AE0, 17'h0, 17'h0AE0, 17'h0};
        check("loop_len", 32'(got_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < got_q.size(); i++)
            check($sformatf("loop_payload[%0d]", i), 32'(got_q[i]), 32'(exp042[i]));
        run_seq(7'h10, 0, 0, 0, 2'd0, 8'd0, 7'd0);
        check("loop_exhausted_len", 32'(got_q.size()), 32'd3);

        // Address wrap from 7F to 00, with back-pressure.
        rom_mem[7'h7F] = 20'h00001;
        rom_mem[7'h00] = 20'h80000;
        run_seq(7'h7F, 1, 0, 0, 2'd0, 8'd0, 7'd0);
        check("wrap_len", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check("wrap_p0", 32'(got_q[0]), 32'h00001);
            check("wrap_p1", 32'(got_q[1]), 32'h00000);
        end

        // Hold cmd_ready low for 5 cycles in ISSUE.
        rom_mem[7'h30] = 20'h8ABCD;
        @(posedge avl_clk); #1;
        cmd_if.cmd_ready = 1'b0; start = 1'b1; start_addr = 7'h30;
        @(posedge avl_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge avl_clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge avl_clk);
            check("bp_valid", 32'(cmd_if.cmd_valid), 32'd1);
            check("bp_payload", 32'(cmd_if.cmd_payload), 32'h0ABCD);
            check("bp_pc", 32'(rom_rdaddress), 32'h30);
        end
        #1 cmd_if.cmd_ready = 1'b1;
        @(negedge avl_clk);
        check("bp_done", 32'(done), 32'd1);

        // Reset while in ISSUE aborts immediately.
        rom_mem[7'h20] = 20'h00123;
        rom_mem[7'h21] = 20'h80000;
        @(posedge avl_clk); #1;
        cmd_if.cmd_ready = 1'b0; start = 1'b1; start_addr = 7'h20;
        @(posedge avl_clk); #1;
        start = 1'b0;
        got_valid = 0;
        for (int i = 0; i < 10 && !got_valid; i++) begin
            @(negedge avl_clk);
            got_valid = cmd_if.cmd_valid;
        end
        check("rst_reached_issue", 32'(got_valid), 32'd1);
        avl_reset_n = 1'b0;
        #1;
        check("rst_valid_now", 32'(cmd_if.cmd_valid), 32'd0);
        check("rst_busy_now", 32'(busy), 32'd0);
        check("rst_pc_now", 32'(rom_rdaddress), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge avl_clk);
            check("rst_no_done", 32'(done), 32'd0);
            check("rst_no_valid", 32'(cmd_if.cmd_valid), 32'd0);
        end
        avl_reset_n = 1'b1;
        model_reset();
        cmd_if.cmd_ready = 1'b1;
        run_seq(7'h20, 0, 0, 0, 2'd0, 8'd0, 7'd0);

        // Start and ld_cnt while busy are ignored; counter loads collide with start in IDLE.
        run_seq(7'h10, 0, 1, 1, 2'd1, 8'd1, 7'h10);
        run_seq(7'h10, 1, 1, 0, 2'd0, 8'd0, 7'd0);

        // Random programs against the model.
        for (int it = 0; it < 12; it++) begin
            b   = 7'($urandom_range(0, 127));
            len = int'($urandom_range(3, 6));
            for (int i = 0; i < len; i++)
                rom_mem[b + 7'(i)] = {(i == len - 1), 2'($urandom_range(0, 3)), 17'($urandom)};
            for (int k = 1; k <= 3; k++)
                do_load(2'(k), 8'($urandom_range(0, 3)), b + 7'($urandom_range(0, len - 1)));
            do_load(2'd0, 8'd5, b);
            run_seq(b, (it % 3) != 0, (it % 2) == 1, (it % 4) == 2, 2'd2,
                    8'($urandom_range(0, 2)), b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rw_manager_m10_inst_seq.md
RW_MANAGER_M10_INST_SEQ -- requirements
Module: rw_manager_m10_inst_seq

Interface
REQ-001 SHALL use one clock and an asynchronous, active-low reset: avl_clk clocks every flop; avl_reset_n clears every flop immediately when low.
REQ-002 SHALL have parameter ADDR_W, default 7, meaning instruction ROM address width.
REQ-003 SHALL have parameter INST_W, default 20, meaning instruction word width.
REQ-004 SHALL have parameter CNT_W, default 8, meaning loop counter width.
REQ-005 avl_clk  in  1  clock.
REQ-006 avl_reset_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  pulse; begin sequence at start_addr.
REQ-008 start_addr  in  ADDR_W  first instruction address.
REQ-009 ld_cnt  in  1  load strobe for loop counter ld_sel.
REQ-010 ld_sel  in  2  counter select, 1..3; 0 is invalid.
REQ-011 ld_cnt_val  in  CNT_W  loop count to load.
REQ-012 ld_jump_addr  in  ADDR_W  jump target to load.
REQ-013 rom_rdaddress  out  ADDR_W  instruction ROM read address.
REQ-014 rom_q  in  INST_W  ROM data, valid one cycle after the address is sampled.
REQ-015 cmd_valid  out  1  command available.
REQ-016 cmd_ready  in  1  datapath accepts command.
REQ-017 cmd_payload  out  17  instruction bits [16:0].
REQ-018 busy  out  1  high outside IDLE.
REQ-019 done  out  1  one-cycle pulse after END instruction accepted.

Function
REQ-020 Instruction fields SHALL be: [19] END; [18:17] JSEL (0 = no jump, 1..3 = loop counter); [16:0] payload.
REQ-021 FSM states SHALL be IDLE, ADDR, DATA, ISSUE.
REQ-022 IDLE: start=1 SHALL load pc=start_addr and move to ADDR.
REQ-023 ADDR: rom_rdaddress=pc; next state is DATA unconditionally.
REQ-024 DATA: rom_q SHALL be captured into the instruction register; next state is ISSUE.
REQ-025 ISSUE: cmd_valid=1 and cmd_payload is held stable until cmd_valid&&cmd_ready.
REQ-026 On handshake with END=1: next state is IDLE and done=1 in the following cycle; JSEL is ignored.
REQ-027 On handshake with JSEL=k!=0 and cnt[k]!=0: cnt[k] decrements, pc=jump[k], next state is ADDR.
REQ-028 On handshake with JSEL=k!=0 and cnt[k]==0: cnt[k] is not reloaded, pc=pc+1, next state is ADDR.
REQ-029 On handshake with JSEL=0: pc=pc+1, next state is ADDR.
REQ-030 pc+1 SHALL wrap modulo 2^ADDR_W (7F->00).
REQ-031 Loop count N SHALL give N jumps, so a loop body executes N+1 times.
REQ-032 ld_cnt SHALL be honoured only in IDLE with ld_sel!=0; otherwise it is ignored.
REQ-033 start while busy SHALL be ignored; start and ld_cnt in the same IDLE cycle both take effect.
REQ-034 Latency: start to first cmd_valid is 3 cycles; with cmd_ready held high, one command issues per 3 cycles.
REQ-035 rom_rdaddress SHALL equal pc in every state.

Reset
REQ-036 Reset SHALL set state=IDLE, pc=0, cnt[1..3]=0, jump[1..3]=0, instruction register=0, cmd_valid=0, cmd_payload=0, busy=0, done=0.
REQ-037 Reset mid-sequence SHALL abort immediately, with no done pulse and no further cmd_valid.

Structure
REQ-038 Shared package rw_manager_m10_pkg SHALL hold the field bit positions (END, JSEL, payload), the state encoding, and the ADDR_W, INST_W and CNT_W defaults.
REQ-039 Sub-module rw_manager_m10_loop_cnt SHALL hold the three counter/jump-target pairs, the load path, the decrement path and the zero flags.
REQ-040 The ROM SHALL be external; this block is its sole reader.

Verification
REQ-041 ROM 00=080180, start_addr=00, cmd_ready=1 -> cmd_valid in cycle 3, payload 00180, done one cycle after handshake.
REQ-042 ld_sel=1, ld_cnt_val=2, ld_jump_addr=10; ROM 10=000000, 11=020AE0, 12=080000; start at 10 -> payload sequence 0,0AE0,0,0AE0,0,0AE0,0 then done; cnt[1]=0 at end.
REQ-043 cmd_ready low for 5 cycles in ISSUE -> cmd_valid and cmd_payload stable throughout, pc unchanged.
REQ-044 start_addr=7F, ROM 7F=000001, 00=080000 -> payloads 00001, 00000 issued, pc wraps to 00, done pulses.
REQ-045 avl_reset_n asserted in ISSUE -> cmd_valid=0 and busy=0 immediately, no done; restarting after release runs normally.
REQ-046 start and ld_cnt asserted while busy -> both ignored; sequence and counters unchanged.
